// File: rtl/tree_accumulator.sv
// Accumulates adder-tree tile sums into a dot product, then rounds/saturates to IL.FL
// behind a valid/ready output. Define TREE_ACC_ROUND_EN for round-half-up; default truncates.
module tree_accumulator #(
  parameter int IL    = 8,
  parameter int FL    = 12,
  parameter int GUARD = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4+2*(IL+FL)-1:0]     in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IL+FL-1:0]           out_data,
  output logic                       out_sat,
  output logic                       out_ovf
);

  localparam int IW = 4 + 2*(IL+FL);
  localparam int AW = IW + GUARD;
  localparam int OW = IL + FL;
  localparam int CW = GUARD + 1;

  localparam logic [CW-1:0]      CNT_MAX = {1'b1, {GUARD{1'b0}}};
  localparam logic signed [AW:0] MAXV    = {{(AW+2-OW){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW:0] MINV    = {{(AW+2-OW){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic {ACCUM, FINAL} state_t;

  state_t                state_reg, state_next;
  logic signed [AW-1:0]  acc_reg;
  logic                  first_reg;
  logic [CW-1:0]         cnt_reg;
  logic                  ovf_reg;
  logic                  out_valid_reg;
  logic [OW-1:0]         out_data_reg;
  logic                  out_sat_reg;
  logic                  out_ovf_reg;

  logic                  accept;
  logic                  load;
  logic signed [AW-1:0]  in_ext;
  logic signed [AW:0]    acc_wide;
  logic signed [AW:0]    rnd_sum;
  logic signed [AW:0]    shifted;
  logic [OW-1:0]         conv_data;
  logic                  conv_sat;

  // Sign-extend the tree sum into the guard bits.
  assign in_ext[IW-1:0] = in_data;
  generate
    for (genvar gi = IW; gi < AW; gi++) begin : g_sext
      assign in_ext[gi] = in_data[IW-1];
    end
  endgenerate

  assign acc_wide = {acc_reg[AW-1], acc_reg};

`ifdef TREE_ACC_ROUND_EN
  localparam logic signed [AW:0] HALF = {{(AW+1-FL){1'b0}}, 1'b1, {(FL-1){1'b0}}};
  assign rnd_sum = acc_wide + HALF;
`else
  assign rnd_sum = acc_wide;
`endif

  assign shifted = rnd_sum >>> FL;

  always_comb begin
    conv_data = shifted[OW-1:0];
    conv_sat  = 1'b0;
    if (shifted > MAXV) begin
      conv_data = MAXV[OW-1:0];
      conv_sat  = 1'b1;
    end else if (shifted < MINV) begin
      conv_data = MINV[OW-1:0];
      conv_sat  = 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = (state_reg == ACCUM);
    accept     = in_valid && (state_reg == ACCUM);
    load       = (state_reg == FINAL) && (!out_valid_reg || out_ready);
    case (state_reg)
      ACCUM:   if (accept && in_last) state_next = FINAL;
      FINAL:   if (load)              state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ACCUM;
      acc_reg       <= '0;
      first_reg     <= 1'b1;
      cnt_reg       <= '0;
      ovf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sat_reg   <= 1'b0;
      out_ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        acc_reg   <= (first_reg ? '0 : acc_reg) + in_ext;
        first_reg <= 1'b0;
        if (cnt_reg == CNT_MAX) ovf_reg <= 1'b1;
        else                    cnt_reg <= cnt_reg + 1'b1;
      end
      // A load and a consume in the same cycle keep out_valid high with new data.
      if (load) begin
        first_reg     <= 1'b1;
        cnt_reg       <= '0;
        ovf_reg       <= 1'b0;
        out_valid_reg <= 1'b1;
        out_data_reg  <= conv_data;
        out_sat_reg   <= conv_sat;
        out_ovf_reg   <= ovf_reg;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sat   = out_sat_reg;
  assign out_ovf   = out_ovf_reg;

endmodule
